// File: rtl/scytale_decryption.sv
// -----------------------------------------------------------------------------
// scytale_decryption
//
// Collects a message of characters into a buffer until the start-decryption
// token arrives. It then replays the buffer in scytale order: output
// character k is buf[(k mod N)*M + (k div N)], using the key captured with
// the token. Indices at or past the stored length produce 0.
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : synchronous reset, active HIGH (asserted when 1)
//   data_i  : input character
//   valid_i : data_i qualifier (ignored while busy)
//   key_N   : number of columns, captured with the token
//   key_M   : number of rows, captured with the token
//   data_o  : decrypted character (holds its value while valid_o=0)
//   valid_o : data_o qualifier
//   busy    : high from the cycle after the token until output completes
// -----------------------------------------------------------------------------
module scytale_decryption #(
    parameter int                  D_WIDTH                = 8,
    parameter int                  KEY_WIDTH              = 8,
    parameter int                  MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    // Character count needs to represent 0..MAX_NOF_CHARS inclusive.
    localparam int CNT_W   = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW      = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    // Wide enough that col*M + row never wraps for any key value, so an
    // oversized key can never alias back into the valid buffer range.
    localparam int IDX_MIN = $clog2(MAX_NOF_CHARS) + 1;
    localparam int IDX_W   = (IDX_MIN > 2 * KEY_WIDTH + 1) ? IDX_MIN : 2 * KEY_WIDTH + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     wr_cnt_q,  wr_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [KEY_WIDTH-1:0] n_q,       n_d;
    logic [KEY_WIDTH-1:0] m_q,       m_d;
    logic [KEY_WIDTH-1:0] col_q,     col_d;     // k mod N
    logic [IDX_W-1:0]     row_q,     row_d;     // k div N
    logic [IDX_W-1:0]     base_q,    base_d;    // col * M, kept incrementally
    logic [D_WIDTH-1:0]   data_q,    data_d;
    logic                 valid_q,   valid_d;

    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
    logic                 wr_en;
    logic                 token_seen;
    logic                 emit_more;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_in_range;

    assign token_seen  = valid_i && (data_i == START_DECRYPTION_TOKEN);
    assign emit_more   = (out_cnt_q != wr_cnt_q);
    assign rd_idx      = base_q + row_q;
    assign rd_in_range = (rd_idx < IDX_W'(wr_cnt_q));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: a default assignment first keeps every path assigned, so no
        // latch is inferred.
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (token_seen && (wr_cnt_q != '0)) state_d = EMIT;
            EMIT:    if (!emit_more)                     state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        out_cnt_d = out_cnt_q;
        n_d       = n_q;
        m_d       = m_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (token_seen) begin
                    // An empty message is ignored; counters stay as they are.
                    if (wr_cnt_q != '0) begin
                        n_d       = key_N;
                        m_d       = key_M;
                        col_d     = '0;
                        row_d     = '0;
                        base_d    = '0;
                        out_cnt_d = '0;
                    end
                end else if (valid_i && (wr_cnt_q < CNT_W'(MAX_NOF_CHARS))) begin
                    // Full buffer silently drops further characters.
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end

            EMIT: begin
                if (emit_more) begin
                    valid_d   = 1'b1;
                    data_d    = rd_in_range ? mem[rd_idx[AW-1:0]] : '0;
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    // Column walks 0..N-1; on wrap the row advances. This
                    // replaces k mod N / k div N without a divider.
                    if (col_q == n_q - KEY_WIDTH'(1)) begin
                        col_d  = '0;
                        base_d = '0;
                        row_d  = row_q + IDX_W'(1);
                    end else begin
                        col_d  = col_q + KEY_WIDTH'(1);
                        base_d = base_q + IDX_W'(m_q);
                    end
                end else begin
                    // Final busy cycle: drop the message.
                    wr_cnt_d = '0;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_cnt_q  <= '0;
            out_cnt_q <= '0;
            n_q       <= '0;
            m_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            out_cnt_q <= out_cnt_d;
            n_q       <= n_d;
            m_q       <= m_d;
            col_q     <= col_d;
            row_q     <= row_d;
            base_q    <= base_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // NOTE: the message buffer is deliberately not reset; wr_cnt alone says
    // which entries are meaningful, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy    = (state_q == EMIT);

endmodule
